// File: rtl/data_memory.sv
// data_memory: 2**ADDR_W x DATA_W store with synchronous write and registered, read-first read.
// Optional feature macro DATA_MEMORY_CLEAR_EN adds a post-reset zeroing sweep with busy/err reporting.
module data_memory #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic              we_i,
  input  logic              re_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] dout_q;
  logic [DATA_W-1:0] dout_d;
  logic              access_ok;
  logic              sweep_we;
  logic [ADDR_W-1:0] cc_q;

`ifdef DATA_MEMORY_CLEAR_EN
  localparam logic [ADDR_W-1:0] CC_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] CC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e            state_q;
  state_e            state_d;
  logic [ADDR_W-1:0] cc_d;
  logic              busy_q;
  logic              busy_d;
  logic              err_q;
  logic              err_d;

  // Control state: sweep FSM, clear counter, busy decode and sticky error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_CLEAR;
      cc_q    <= {ADDR_W{1'b0}};
      busy_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cc_q    <= cc_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: walk every location once, then stay in READY until reset.
  always_comb begin
    state_d   = state_q;
    cc_d      = cc_q;
    err_d     = err_q;
    sweep_we  = 1'b0;
    access_ok = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        sweep_we = 1'b1;
        cc_d     = cc_q + CC_ONE;
        if (we_i || re_i) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        if (cc_q == CC_LAST) begin
          state_d = ST_READY;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_READY: begin
        access_ok = 1'b1;
      end
      // An unreachable encoding restarts the sweep so memory is never trusted uncleared.
      default: begin
        state_d = ST_CLEAR;
        cc_d    = {ADDR_W{1'b0}};
      end
    endcase
    busy_d = (state_d == ST_CLEAR);
  end

  assign busy_o = busy_q;
  assign err_o  = err_q;
`else
  assign access_ok = 1'b1;
  assign sweep_we  = 1'b0;
  assign cc_q      = {ADDR_W{1'b0}};
  assign busy_o    = 1'b0;
  assign err_o     = 1'b0;
`endif

  // Storage: sweep writes win; no reset so contents are untouched by rst_ni itself.
  always_ff @(posedge clk_i) begin
    if (sweep_we) begin
      mem_q[cc_q] <= {DATA_W{1'b0}};
    end else if (access_ok && we_i) begin
      mem_q[addr_i] <= din_i;
    end
  end

  // Read path samples the pre-edge contents, which gives read-first on a same-address write.
  always_comb begin
    if (access_ok && re_i) begin
      dout_d = mem_q[addr_i];
    end else begin
      dout_d = dout_q;
    end
  end

  // Registered read data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dout_q <= {DATA_W{1'b0}};
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout_o = dout_q;

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: behavioural model compared every cycle, plus literal pins.
// Follows DATA_MEMORY_CLEAR_EN to pick the matching expectations.
module tb_data_memory;

  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 256;
`ifdef DATA_MEMORY_CLEAR_EN
  localparam int CLR_EDGES = DEPTH;
`else
  localparam int CLR_EDGES = 0;
`endif

  logic          clk_i  = 1'b0;
  logic          rst_ni = 1'b0;
  logic [AW-1:0] addr_i = '0;
  logic [DW-1:0] din_i  = '0;
  logic          we_i   = 1'b0;
  logic          re_i   = 1'b0;
  logic [DW-1:0] dout_o;
  logic          busy_o;
  logic          err_o;

  int n_checks = 0;
  int n_errors = 0;

  data_memory #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .addr_i (addr_i),
    .din_i  (din_i),
    .we_i   (we_i),
    .re_i   (re_i),
    .dout_o (dout_o),
    .busy_o (busy_o),
    .err_o  (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkn(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: memory as a plain array, sweep as a count of busy edges left.
  logic [7:0] m_mem   [DEPTH];
  bit         m_valid [DEPTH];
  logic [7:0] m_dout     = 8'h00;
  bit         m_known    = 1'b1;
  bit         m_err      = 1'b0;
  int         clear_left = CLR_EDGES;
  bit         chk_en     = 1'b0;

  initial begin
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    forever begin
      @(posedge clk_i or negedge rst_ni);
      if (!rst_ni) begin
        clear_left = CLR_EDGES;
        m_dout     = 8'h00;
        m_known    = 1'b1;
        m_err      = 1'b0;
      end else if (clear_left > 0) begin
        if (we_i || re_i) m_err = 1'b1;
        clear_left--;
        if (clear_left == 0) begin
          for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]   = 8'h00;
            m_valid[i] = 1'b1;
          end
        end
      end else begin
        if (re_i) begin
          m_dout  = m_mem[addr_i];
          m_known = m_valid[addr_i];
        end
        if (we_i) begin
          m_mem[addr_i]   = din_i;
          m_valid[addr_i] = 1'b1;
        end
      end
      #1;
      if (chk_en) begin
        if (m_known) chk8("model_dout", dout_o, m_dout);
        chk1("model_busy", busy_o, clear_left > 0);
        chk1("model_err", err_o, m_err);
      end
    end
  end

  task automatic drive(input logic we, input logic re, input logic [7:0] a, input logic [7:0] d);
    we_i   = we;
    re_i   = re;
    addr_i = a;
    din_i  = d;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] zaddr [4];
    zaddr[0] = 8'h00; zaddr[1] = 8'h7F; zaddr[2] = 8'hFF; zaddr[3] = 8'h05;

    drive(1'b0, 1'b0, 8'h00, 8'h00);
    rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk8("reset_dout", dout_o, 8'h00);
    chk1("reset_err", err_o, 1'b0);
`ifdef DATA_MEMORY_CLEAR_EN
    chk1("reset_busy", busy_o, 1'b1);
`else
    chk1("reset_busy", busy_o, 1'b0);
`endif
    #5 rst_ni = 1'b1;
    chk_en = 1'b1;

`ifdef DATA_MEMORY_CLEAR_EN
    // Sweep length, with an illegal write presented on edge 3.
    n = 0;
    while (n < 400) begin
      tick();
      n++;
      if (n == 2) begin
        chk1("err_before_clear_access", err_o, 1'b0);
        drive(1'b1, 1'b0, 8'h05, 8'hFF);
      end
      if (n == 3) begin
        chk1("err_after_clear_access", err_o, 1'b1);
        drive(1'b0, 1'b0, 8'h00, 8'h00);
      end
      if (!busy_o) break;
    end
    chkn("clear_edges", n, 256);
    chk1("err_sticky_after_clear", err_o, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, zaddr[i], 8'h00);
      tick();
      chk8("cleared_read", dout_o, 8'h00);
    end
`else
    chk1("busy_after_release", busy_o, 1'b0);
    drive(1'b1, 1'b0, 8'hFF, 8'h3C);
    tick();
    drive(1'b0, 1'b1, 8'hFF, 8'h00);
    tick();
    chk8("first_edge_write", dout_o, 8'h3C);
    chk1("err_macro_off", err_o, 1'b0);
    chk1("busy_macro_off", busy_o, 1'b0);
`endif

    // Write then read back, then hold with re low.
    drive(1'b1, 1'b0, 8'h10, 8'hA5);
    tick();
    drive(1'b0, 1'b1, 8'h10, 8'h00);
    tick();
    chk8("write_read", dout_o, 8'hA5);
    drive(1'b0, 1'b0, 8'h10, 8'h00);
    tick();
    tick();
    chk8("dout_hold", dout_o, 8'hA5);

    // Read-first collision.
    drive(1'b1, 1'b0, 8'h20, 8'h11);
    tick();
    drive(1'b1, 1'b1, 8'h20, 8'h22);
    tick();
    chk8("collision_old", dout_o, 8'h11);
    drive(1'b0, 1'b1, 8'h20, 8'h00);
    tick();
    chk8("collision_new", dout_o, 8'h22);
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    tick();

`ifdef DATA_MEMORY_CLEAR_EN
    // Fresh sweep, set err mid-way, then reset at edge 100 and time the restart.
    @(posedge clk_i);
    #2 rst_ni = 1'b0;
    #3 rst_ni = 1'b1;
    n = 0;
    while (n < 100) begin
      tick();
      n++;
      if (n == 50) drive(1'b0, 1'b1, 8'h33, 8'h00);
      if (n == 51) drive(1'b0, 1'b0, 8'h00, 8'h00);
    end
    chk1("err_set_mid_sweep", err_o, 1'b1);
    #1 rst_ni = 1'b0;
    #1;
    chk8("midsweep_reset_dout", dout_o, 8'h00);
    chk1("midsweep_reset_err", err_o, 1'b0);
    chk1("midsweep_reset_busy", busy_o, 1'b1);
    #3 rst_ni = 1'b1;
    n = 0;
    while (n < 400) begin
      tick();
      n++;
      if (!busy_o) break;
    end
    chkn("restart_clear_edges", n, 256);
    chk1("err_after_restart", err_o, 1'b0);
`else
    // dout holds 0x22 here; reset must zero it at once.
    @(posedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    chk8("midrun_reset_dout", dout_o, 8'h00);
    chk1("midrun_reset_err", err_o, 1'b0);
    #3 rst_ni = 1'b1;
`endif

    // Randomized traffic, biased to a small address window so reads hit written words.
    for (int i = 0; i < 1500; i++) begin
      logic [7:0] a;
      if ($urandom_range(0, 3) != 0) a = 8'($urandom_range(0, 15));
      else a = 8'($urandom_range(0, 255));
      drive(($urandom_range(0, 9) < 4), ($urandom_range(0, 1) == 1), a, 8'($urandom));
      tick();
    end
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/data_memory.md
# data_memory

Data memory for the 8-bit datapath. It sits directly downstream of the MUX Data stage and takes that stage's 8-bit output (literal k8 or regB) as write data. Reads are registered and writes are synchronous. With the clear feature compiled in, the block runs a post-reset clear sequencer that zeroes every location and holds `busy` high until the sweep completes.

## Interface
- `ADDR_W`, 8, address width; depth = 2**ADDR_W words.
- `DATA_W`, 8, word width; must match the MUX Data output width.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `addr`  in  ADDR_W  word address for read or write.
- `din`  in  DATA_W  write data from MUX Data output.
- `we`  in  1  write enable.
- `re`  in  1  read enable.
- `dout`  out  DATA_W  registered read data.
- `busy`  out  1  high while the clear sweep runs; accesses are ignored.
- `err`  out  1  sticky flag; set when `we` or `re` is high while `busy` is high.

## Operation
- Storage: array of 2**ADDR_W words of DATA_W bits. `addr` is used unmodified. There is no wrap or truncation beyond the ADDR_W bits.
- FSM, two states:
  - CLEAR: clear counter `cc` walks 0 .. 2**ADDR_W-1. Each edge writes 0 to mem[cc] and increments `cc`. On the edge that writes the last location, go to READY.
  - READY: normal access. No exit except reset.
- Reset, asynchronous, while `rst_n`=0:
  - State = CLEAR (macro defined) or READY (macro undefined).
  - `cc`=0, `dout`=0, `err`=0.
  - `busy`=1 (macro defined) or 0 (macro undefined).
  - Memory contents are not touched by reset itself.
- Write, READY: if `we`=1, then mem[addr] <= din on the edge.
- Read, READY: if `re`=1, then dout <= mem[addr] on the edge. If `re`=0, `dout` holds its value.
- `we`=1 and `re`=1 to the same address on the same edge: read-first. `dout` gets the old contents; the new data is visible on the next read.
- Access during CLEAR:
  - `we` and `re` are ignored; memory is written only by the sweep and `dout` holds.
  - `err` is set to 1 and stays 1 until reset.
- Reset asserted mid-sweep: the sweep restarts from `cc`=0 after release. Locations already cleared are cleared again.
- `busy` is a registered output decoded from state: CLEAR gives 1, READY gives 0.

## Timing
- Read latency: 1 cycle. With `addr`/`re` presented before edge N, data is valid on `dout` after edge N and holds until the next enabled read or reset.
- Write latency: 0 cycles to storage. A read issued on edge N+1 of a location written on edge N returns the new data.
- Clear duration, macro defined: exactly 2**ADDR_W rising edges after `rst_n` rises. With ADDR_W=8, `busy` falls after the 256th edge, and the first accepted access is on edge 257.
- There is no backpressure other than `busy`. The producer (control unit) must hold off accesses while `busy`=1.

## Configuration
- `DATA_MEMORY_CLEAR_EN`
  - Defined: the CLEAR state, the `cc` counter and the sweep are present. After every reset all locations read 0 once `busy` is low.
  - Undefined: the FSM is tied to READY. `busy` is constant 0 and `err` is constant 0. The block accepts accesses on the first edge after reset, and memory contents after power-up are undefined (X in simulation).

## Test plan
- Clear sweep (macro on, ADDR_W=8): release reset and count edges -> `busy`=1 for exactly 256 edges. Afterwards, reads of 0x00, 0x7F and 0xFF return 0x00, and `err`=0.
- Write/read: write 0xA5 to 0x10, then read 0x10 on the next edge -> `dout`=0xA5 one cycle after the read edge. With `re`=0 afterwards, `dout` stays 0xA5.
- Read-first collision: mem[0x20]=0x11. Apply `we`=`re`=1, addr 0x20, din 0x22 -> `dout`=0x11. The next read of 0x20 returns 0x22.
- Access during clear: after reset, assert `we`=1 addr 0x05 din 0xFF at edge 3 -> `err`=1 from edge 3 onward. After `busy` drops, mem[0x05] reads 0x00.
- Reset mid-sweep: assert `rst_n`=0 at edge 100 and release -> `busy`=1 for a full 256 edges after release, and `dout`=0 and `err`=0 immediately on reset.
- Macro off: release reset with `busy`=0 and write 0x3C to 0xFF on the first edge -> a read on the second edge returns 0x3C, and `err` stays 0 throughout.
